// File: rtl/credit_tx.sv
// Credit-based stream transmitter: forwards a valid/ready stream to a remote buffer
// with no backpressure wire, tracking free remote slots with a local credit counter.
module credit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 8,
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  credit_i,
  output logic [CNT_WIDTH-1:0]  credit_cnt_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  err;
  logic                  hs;
  logic                  ovf;

  // Return a credit without wrapping; a credit at full count is an error
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  assign ready_o = !rst_i && (cnt != '0);
  assign hs      = valid_i && ready_o;
  assign ovf     = credit_i && !hs && (cnt == CNT_MAX);

  // Stage p1: registered beat towards the remote buffer plus credit bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= CNT_MAX;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err     <= 1'b0;
    end else begin
      vld_p1 <= hs;
      if (hs) begin
        data_p1 <= data_i;
      end
      if (hs && !credit_i) begin
        cnt <= cnt - 1'b1;
      end else if (!hs && credit_i) begin
        cnt <= sat_inc(cnt);
      end
      if (ovf) begin
        err <= 1'b1;
      end
    end
  end

  assign tx_data_o    = data_p1;
  assign tx_valid_o   = vld_p1;
  assign credit_cnt_o = cnt;
  assign idle_o       = (cnt == CNT_MAX) && !vld_p1;
  assign err_o        = err;

endmodule

// File: tb/tb_credit_tx.sv
// Directed and randomised checks of credit_tx against hand-computed values and a
// depth-8 remote buffer model.
module tb_credit_tx;

  localparam int DATA_WIDTH = 32;
  localparam int CREDITS    = 8;
  localparam int CNT_WIDTH  = $clog2(CREDITS + 1);

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] tx_data_o;
  logic                  tx_valid_o;
  logic                  credit_i;
  logic [CNT_WIDTH-1:0]  credit_cnt_o;
  logic                  idle_o;
  logic                  err_o;

  int n_tests = 0;
  int n_fail  = 0;

  credit_tx #(
    .DATA_WIDTH(DATA_WIDTH),
    .CREDITS   (CREDITS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .credit_i    (credit_i),
    .credit_cnt_o(credit_cnt_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [DATA_WIDTH-1:0] remote[$];
  logic [DATA_WIDTH-1:0] sent[$];
  logic [DATA_WIDTH-1:0] exp_d;
  int                    mcnt;
  logic                  hs;
  logic                  pending;

  initial begin
    rst_i    = 1'b1;
    data_i   = '0;
    valid_i  = 1'b0;
    credit_i = 1'b0;

    // Reset held for two edges
    step();
    step();
    chk("rst_ready", ready_o, 0);
    chk("rst_cnt", credit_cnt_o, 8);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_txv", tx_valid_o, 0);
    chk("rst_txd", tx_data_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);

    // Burst to empty
    valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_i = k;
      chk("burst_ready", ready_o, 1);
      step();
      chk("burst_txv", tx_valid_o, 1);
      chk("burst_txd", tx_data_o, k);
      chk("burst_cnt", credit_cnt_o, 7 - k);
    end
    data_i = 8;
    chk("empty_ready", ready_o, 0);
    step();
    chk("empty_txv", tx_valid_o, 0);
    chk("empty_cnt", credit_cnt_o, 0);
    chk("empty_txd_hold", tx_data_o, 7);
    chk("empty_idle", idle_o, 0);

    // Refill with one credit: no same-cycle bypass
    credit_i = 1'b1;
    chk("refill_ready_pre", ready_o, 0);
    step();
    credit_i = 1'b0;
    chk("refill_cnt", credit_cnt_o, 1);
    chk("refill_ready", ready_o, 1);
    chk("refill_txv0", tx_valid_o, 0);
    step();
    valid_i = 1'b0;
    chk("refill_txv", tx_valid_o, 1);
    chk("refill_txd", tx_data_o, 8);
    chk("refill_cnt0", credit_cnt_o, 0);
    step();
    chk("refill_txv_end", tx_valid_o, 0);

    // Simultaneous handshake and credit at cnt=3
    credit_i = 1'b1;
    repeat (3) step();
    credit_i = 1'b0;
    chk("simul_pre_cnt", credit_cnt_o, 3);
    valid_i  = 1'b1;
    data_i   = 32'hAB;
    credit_i = 1'b1;
    step();
    valid_i  = 1'b0;
    credit_i = 1'b0;
    chk("simul_cnt", credit_cnt_o, 3);
    chk("simul_txv", tx_valid_o, 1);
    chk("simul_txd", tx_data_o, 32'hAB);

    // Overflow at idle
    credit_i = 1'b1;
    repeat (5) step();
    credit_i = 1'b0;
    chk("ovf_pre_cnt", credit_cnt_o, 8);
    chk("ovf_pre_idle", idle_o, 1);
    chk("ovf_pre_err", err_o, 0);
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    chk("ovf_cnt", credit_cnt_o, 8);
    chk("ovf_err", err_o, 1);
    repeat (3) step();
    chk("ovf_err_sticky", err_o, 1);
    chk("ovf_cnt_hold", credit_cnt_o, 8);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("ovf_err_clr", err_o, 0);
    chk("ovf_cnt_rst", credit_cnt_o, 8);

    // Random traffic against a depth-8 remote buffer model
    mcnt    = CREDITS;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = $urandom;
      end
      credit_i = 1'b0;
      if (remote.size() > 0 && $urandom_range(0, 2) != 0) begin
        void'(remote.pop_front());
        credit_i = 1'b1;
      end
      #1;
      chk("rnd_ready", ready_o, (mcnt != 0));
      hs = valid_i && (mcnt != 0);
      pending = valid_i && !hs;
      if (hs) sent.push_back(data_i);
      mcnt = mcnt - int'(hs) + int'(credit_i);
      step();
      chk("rnd_txv", tx_valid_o, hs);
      if (tx_valid_o) begin
        remote.push_back(tx_data_o);
        if (sent.size() > 0) begin
          exp_d = sent.pop_front();
          chk("rnd_txd", tx_data_o, exp_d);
        end else begin
          chk("rnd_unexpected_beat", 1, 0);
        end
      end
      chk("rnd_overrun", (remote.size() > CREDITS), 0);
      chk("rnd_cnt", credit_cnt_o, mcnt);
      chk("rnd_invariant", credit_cnt_o + remote.size(), CREDITS);
      chk("rnd_err", err_o, 0);
    end

    // Drain the remote buffer and return to idle
    valid_i = 1'b0;
    while (remote.size() > 0) begin
      void'(remote.pop_front());
      credit_i = 1'b1;
      step();
    end
    credit_i = 1'b0;
    step();
    chk("drain_cnt", credit_cnt_o, 8);
    chk("drain_idle", idle_o, 1);
    chk("drain_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
